maxfind_avs: RTL and testbench
==============================

# maxfind_avs

Parametrised, sequential find-maximum peripheral on the Avalon-MM slave bus, the successor of the fixed 5×4-bit combinational max-finder IP. Software pushes up to DEPTH unsigned W-bit elements into an internal buffer, then starts a scan. A state machine compares one element per cycle and reports the maximum value and its index, and optionally the minimum. It sits on the system bus next to the other CE433 lab peripherals and is driven by the Nios II software.

## Interface
- W, 8: element width in bits; legal range 1..16.
- DEPTH, 16: buffer capacity in elements; legal range 2..256.
- IDXW, $clog2(DEPTH): index/pointer width.
- iClk  in  1  system clock.
- iReset_n  in  1  reset, asynchronous, active-low.
- iChipselect_n  in  1  slave select, active-low.
- iWrite_n  in  1  write strobe, active-low, qualified by chip select.
- iRead_n  in  1  read strobe, active-low, qualified by chip select.
- iAddress  in  2  register address.
- iData  in  32  write data.
- oData  out  32  registered read data; resets to 0.

## Operation
- Register map:
  - Addr 0, write: push iData[W-1:0] at buf[count], then count+1. Addr 0, read: {0, count}.
  - Addr 1, write: bit0 = START, bit1 = CLEAR; CLEAR wins if both are set. Addr 1, read: STATUS = bit0 busy, bit1 done, bit2 full (count==DEPTH), bit3 overflow (sticky), bit4 empty (the last scan had count 0), [23:8] count.
  - Addr 2, read: [15:0] max value and [31:16] min value, each zero-extended.
  - Addr 3, read: [15:0] max index and [31:16] min index.
  - Writes to addresses 2 and 3 are ignored.
- States:
  - IDLE: pushes are accepted.
  - START from IDLE or DONE → SCAN, ptr=0. If count==0, go directly to DONE with empty=1 and results 0.
  - SCAN: on each cycle, compare buf[ptr]. ptr==0 loads max=min=buf[0] and idx=0. Otherwise update max when buf[ptr] > max (strict), and min when buf[ptr] < min (strict). Ties keep the lowest index. When ptr==count-1 → DONE.
  - DONE: results are held stable. Pushes are accepted and do not disturb the results. START rescans. CLEAR → IDLE.
- CLEAR, in any state:
  - count=0, done=0, overflow=0, empty=0, results=0 → IDLE.
  - Aborts a scan in progress.
- Push while full: the data is dropped, count is unchanged, overflow=1.
- Push while busy: dropped, overflow=1.
- START while busy: ignored.
- Comparison is unsigned. Elements are stored truncated to W bits.
- Buffer contents are not reset. Only count gates validity.

## Timing
- Reset values:
  - oData, count, results, ptr and flags are 0.
  - State is IDLE.
- Read latency: one cycle. oData updates on the iClk edge where chip select and read are both active. Otherwise oData holds its value.
- Simultaneous read and write in the same cycle: the read returns the pre-write value.
- START accepted at edge E0 with count=N≥1:
  - SCAN from E0.
  - Element k is evaluated at edge E(k+1).
  - busy=0 and done=1 after edge EN, so the scan takes N cycles.
  - A STATUS read issued in cycle EN returns done=1.
- START with N=0: done=1 and empty=1 after E0.
- Reset asserted mid-scan: immediate return to IDLE with all flags cleared.

## Configuration
- MAXFIND_MIN_EN defined: the min value and min index are tracked and returned in the upper halves of addresses 2 and 3.
- MAXFIND_MIN_EN undefined: the min logic is not built and the upper halves read 0. Max behaviour is identical in both builds.

## Structure
- Package maxfind_pkg contains:
  - state enum (IDLE, SCAN, DONE);
  - address constants ADDR_DATA, ADDR_CTRL, ADDR_RES_VAL, ADDR_RES_IDX;
  - STATUS bit positions;
  - CTRL bit positions.
- Sub-module maxfind_core holds the buffer, the state machine and the compare datapath. It exposes push, start, clear, count, flags and results.
- The top level maxfind_avs contains only Avalon-MM register decode and the oData register.

## Test plan
- Reset, then read all four addresses → every read returns 0 and STATUS=0.
- W=8: push 3, 9, 2, 9, 5, then START → busy for exactly 5 cycles. Then max=9, idx=1 (lowest index on tie), and with MIN_EN min=2, idx=2. STATUS = 0x0502.
- Push DEPTH+1 elements → full=1, overflow=1, count=DEPTH. The extra value never appears as a result.
- START with count 0 → done=1 and empty=1 after one edge; addresses 2 and 3 read 0.
- Push 0x1FF with W=8 → stored value is 0xFF, and max after the scan is 0xFF.
- CLEAR issued mid-scan (count 16, cycle 4) → IDLE, count=0, done=0. A new push followed by START scans only the new data.

Source files
------------

// File: rtl/maxfind_pkg.sv
// Shared types and constants for the maxfind_avs find-maximum peripheral.
// Build option MAXFIND_MIN_EN adds minimum tracking (see maxfind_core).
package maxfind_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_RES_VAL = 2'd2;
    localparam logic [1:0] ADDR_RES_IDX = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_EMPTY   = 4;
    localparam int STAT_CNT_LSB = 8;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    function automatic logic [31:0] packHalves(input logic [15:0] lo, input logic [15:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/maxfind_avs_if.sv
// Avalon-MM slave bus bundle for maxfind_avs; clock and reset stay plain ports.
interface maxfind_avs_if;
    logic        iChipselect_n;
    logic        iWrite_n;
    logic        iRead_n;
    logic [1:0]  iAddress;
    logic [31:0] iData;
    logic [31:0] oData;

    modport master (output iChipselect_n, iWrite_n, iRead_n, iAddress, iData, input oData);
    modport slave  (input iChipselect_n, iWrite_n, iRead_n, iAddress, iData, output oData);
endinterface

// File: rtl/maxfind_core.sv
// Element buffer, scan state machine and compare datapath of maxfind_avs.
// With MAXFIND_MIN_EN defined the minimum value/index are tracked as well.
module maxfind_core
    import maxfind_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic            iClk,
    input  logic            iReset_n,
    input  logic            push,
    input  logic [W-1:0]    pushData,
    input  logic            start,
    input  logic            clear,
    output logic [IDXW:0]   count,
    output logic            busy,
    output logic            done,
    output logic            full,
    output logic            overflow,
    output logic            empty,
    output logic [W-1:0]    maxVal,
    output logic [IDXW-1:0] maxIdx,
    output logic [W-1:0]    minVal,
    output logic [IDXW-1:0] minIdx
);

    localparam logic [IDXW:0]   DEPTH_C = (IDXW+1)'(DEPTH);
    localparam logic [IDXW:0]   CNT_ONE = (IDXW+1)'(1);
    localparam logic [IDXW-1:0] PTR_ONE = IDXW'(1);

    state_t          state_r;
    logic [IDXW:0]   count_r;
    logic [IDXW-1:0] ptr_r;
    logic            done_r;
    logic            overflow_r;
    logic            empty_r;
    logic [W-1:0]    maxVal_r;
    logic [IDXW-1:0] maxIdx_r;
    logic [W-1:0]    mem_r [DEPTH];
    logic [W-1:0]    elem_s;
    logic            full_s;
    logic            pushAccept_s;
    logic            isLast_s;

    assign full_s       = (count_r == DEPTH_C);
    assign pushAccept_s = push && (state_r != SCAN) && !full_s;
    assign elem_s       = mem_r[ptr_r];
    assign isLast_s     = ({1'b0, ptr_r} == (count_r - CNT_ONE));

    // Buffer storage: contents are never reset, count alone marks them valid.
    always_ff @(posedge iClk) begin
        if (pushAccept_s) begin
            mem_r[count_r[IDXW-1:0]] <= pushData;
        end
    end

`ifdef MAXFIND_MIN_EN
    logic [W-1:0]    minVal_r;
    logic [IDXW-1:0] minIdx_r;
    assign minVal = minVal_r;
    assign minIdx = minIdx_r;
`else
    assign minVal = '0;
    assign minIdx = '0;
`endif

    // Control state machine, fill counter, sticky flags and running results.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_r    <= IDLE;
            count_r    <= '0;
            ptr_r      <= '0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            empty_r    <= 1'b0;
            maxVal_r   <= '0;
            maxIdx_r   <= '0;
`ifdef MAXFIND_MIN_EN
            minVal_r   <= '0;
            minIdx_r   <= '0;
`endif
        end else if (clear) begin
            state_r    <= IDLE;
            count_r    <= '0;
            ptr_r      <= '0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            empty_r    <= 1'b0;
            maxVal_r   <= '0;
            maxIdx_r   <= '0;
`ifdef MAXFIND_MIN_EN
            minVal_r   <= '0;
            minIdx_r   <= '0;
`endif
        end else begin
            if (push) begin
                if (pushAccept_s) begin
                    count_r <= count_r + CNT_ONE;
                end else begin
                    overflow_r <= 1'b1;
                end
            end
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        ptr_r <= '0;
                        if (count_r == '0) begin
                            state_r  <= DONE;
                            done_r   <= 1'b1;
                            empty_r  <= 1'b1;
                            maxVal_r <= '0;
                            maxIdx_r <= '0;
`ifdef MAXFIND_MIN_EN
                            minVal_r <= '0;
                            minIdx_r <= '0;
`endif
                        end else begin
                            state_r <= SCAN;
                            done_r  <= 1'b0;
                            empty_r <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    // Strict compares so a tie keeps the earlier index.
                    if (ptr_r == '0) begin
                        maxVal_r <= elem_s;
                        maxIdx_r <= '0;
`ifdef MAXFIND_MIN_EN
                        minVal_r <= elem_s;
                        minIdx_r <= '0;
`endif
                    end else begin
                        if (elem_s > maxVal_r) begin
                            maxVal_r <= elem_s;
                            maxIdx_r <= ptr_r;
                        end
`ifdef MAXFIND_MIN_EN
                        if (elem_s < minVal_r) begin
                            minVal_r <= elem_s;
                            minIdx_r <= ptr_r;
                        end
`endif
                    end
                    if (isLast_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + PTR_ONE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign count    = count_r;
    assign busy     = (state_r == SCAN);
    assign done     = done_r;
    assign full     = full_s;
    assign overflow = overflow_r;
    assign empty    = empty_r;
    assign maxVal   = maxVal_r;
    assign maxIdx   = maxIdx_r;

endmodule

// File: rtl/maxfind_avs.sv
// Avalon-MM register front end of the find-maximum peripheral (decode + read register).
// Define MAXFIND_MIN_EN to also report the minimum in the upper result halves.
module maxfind_avs
    import maxfind_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input logic          iClk,
    input logic          iReset_n,
    maxfind_avs_if.slave avs
);

    logic            wrEn_s, rdEn_s;
    logic            push_s, start_s, clear_s;
    logic [IDXW:0]   count_s;
    logic            busy_s, done_s, full_s, overflow_s, empty_s;
    logic [W-1:0]    maxVal_s, minVal_s;
    logic [IDXW-1:0] maxIdx_s, minIdx_s;
    logic [31:0]     rdMux_s;
    logic            unusedData_s;

    assign wrEn_s       = !avs.iChipselect_n && !avs.iWrite_n;
    assign rdEn_s       = !avs.iChipselect_n && !avs.iRead_n;
    assign push_s       = wrEn_s && (avs.iAddress == ADDR_DATA);
    assign start_s      = wrEn_s && (avs.iAddress == ADDR_CTRL) && avs.iData[CTRL_START];
    assign clear_s      = wrEn_s && (avs.iAddress == ADDR_CTRL) && avs.iData[CTRL_CLEAR];
    assign unusedData_s = ^avs.iData;

    maxfind_core #(.W(W), .DEPTH(DEPTH), .IDXW(IDXW)) core (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .push     (push_s),
        .pushData (avs.iData[W-1:0]),
        .start    (start_s),
        .clear    (clear_s),
        .count    (count_s),
        .busy     (busy_s),
        .done     (done_s),
        .full     (full_s),
        .overflow (overflow_s),
        .empty    (empty_s),
        .maxVal   (maxVal_s),
        .maxIdx   (maxIdx_s),
        .minVal   (minVal_s),
        .minIdx   (minIdx_s)
    );

    // Read data selection by register address.
    always_comb begin
        rdMux_s = 32'd0;
        case (avs.iAddress)
            ADDR_DATA:    rdMux_s = 32'(count_s);
            ADDR_CTRL: begin
                rdMux_s[STAT_BUSY]             = busy_s;
                rdMux_s[STAT_DONE]             = done_s;
                rdMux_s[STAT_FULL]             = full_s;
                rdMux_s[STAT_OVF]              = overflow_s;
                rdMux_s[STAT_EMPTY]            = empty_s;
                rdMux_s[STAT_CNT_LSB +: 16]    = 16'(count_s);
            end
            ADDR_RES_VAL: rdMux_s = packHalves(16'(maxVal_s), 16'(minVal_s));
            ADDR_RES_IDX: rdMux_s = packHalves(16'(maxIdx_s), 16'(minIdx_s));
            default:      rdMux_s = 32'd0;
        endcase
    end

    // Read data register: samples pre-write state, holds when not read.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            avs.oData <= 32'd0;
        end else if (rdEn_s) begin
            avs.oData <= rdMux_s;
        end
    end

endmodule

// File: tb/tb_maxfind_avs.sv
// Directed self-checking bench for maxfind_avs (W=8, DEPTH=16).
module tb_maxfind_avs;
    localparam int W = 8;
    localparam int DEPTH = 16;
`ifdef MAXFIND_MIN_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    logic iClk = 1'b0;
    logic iReset_n = 1'b0;
    int   vecCount = 0;
    int   errCount = 0;

    maxfind_avs_if avs();

    maxfind_avs #(.W(W), .DEPTH(DEPTH)) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .avs      (avs)
    );

    always #5 iClk = ~iClk;

    function automatic logic [31:0] expRes(input logic [15:0] mx, input logic [15:0] mn);
        return MIN_EN ? {mn, mx} : {16'd0, mx};
    endfunction

    task automatic avsWrite(input logic [1:0] a, input logic [31:0] d);
        @(negedge iClk);
        avs.iChipselect_n = 1'b0; avs.iWrite_n = 1'b0; avs.iAddress = a; avs.iData = d;
        @(negedge iClk);
        avs.iChipselect_n = 1'b1; avs.iWrite_n = 1'b1;
    endtask

    task automatic avsRead(input logic [1:0] a, output logic [31:0] d);
        @(negedge iClk);
        avs.iChipselect_n = 1'b0; avs.iRead_n = 1'b0; avs.iAddress = a;
        @(negedge iClk);
        avs.iChipselect_n = 1'b1; avs.iRead_n = 1'b1;
        d = avs.oData;
    endtask

    task automatic waitDone(output logic ok, output logic [31:0] st);
        ok = 1'b0;
        st = 32'd0;
        for (int i = 0; i < 64 && !ok; i++) begin
            avsRead(2'd1, st);
            if (st[1] && !st[0]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        avs.iChipselect_n = 1'b1; avs.iWrite_n = 1'b1; avs.iRead_n = 1'b1;
        avs.iAddress = 2'd0; avs.iData = 32'd0;
        iReset_n = 1'b0;
        repeat (3) @(negedge iClk);
        vecCount++;
        if (avs.oData !== 32'd0) begin errCount++; $display("FAIL reset_odata got %h exp %h", avs.oData, 32'd0); end
        iReset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            avsRead(2'(a), rd);
            vecCount++;
            if (rd !== 32'd0) begin errCount++; $display("FAIL reset_addr%0d got %h exp %h", a, rd, 32'd0); end
        end
    endtask

    task automatic test_scan();
        logic [31:0] rd;
        int busyCycles;
        logic seenDone;
        avsWrite(2'd1, 32'h2);
        avsWrite(2'd0, 32'd3); avsWrite(2'd0, 32'd9); avsWrite(2'd0, 32'd2);
        avsWrite(2'd0, 32'd9); avsWrite(2'd0, 32'd5);
        avsWrite(2'd1, 32'h1);
        avs.iChipselect_n = 1'b0; avs.iRead_n = 1'b0; avs.iAddress = 2'd1;
        busyCycles = 0; seenDone = 1'b0;
        for (int i = 0; i < 20 && !seenDone; i++) begin
            @(negedge iClk);
            if (avs.oData[0]) busyCycles++;
            else if (avs.oData[1]) seenDone = 1'b1;
        end
        rd = avs.oData;
        avs.iChipselect_n = 1'b1; avs.iRead_n = 1'b1;
        vecCount++;
        if (busyCycles !== 5 || !seenDone) begin errCount++; $display("FAIL scan_busy_cycles got %0d done=%0b exp 5 done=1", busyCycles, seenDone); end
        vecCount++;
        if (rd !== 32'h0000_0502) begin errCount++; $display("FAIL scan_status got %h exp %h", rd, 32'h502); end
        avsRead(2'd2, rd);
        vecCount++;
        if (rd !== expRes(16'd9, 16'd2)) begin errCount++; $display("FAIL scan_val got %h exp %h", rd, expRes(16'd9, 16'd2)); end
        avsRead(2'd3, rd);
        vecCount++;
        if (rd !== expRes(16'd1, 16'd2)) begin errCount++; $display("FAIL scan_idx got %h exp %h", rd, expRes(16'd1, 16'd2)); end
        avsRead(2'd0, rd);
        vecCount++;
        if (rd !== 32'd5) begin errCount++; $display("FAIL scan_count got %h exp %h", rd, 32'd5); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic ok;
        avsWrite(2'd1, 32'h2);
        for (int i = 0; i < DEPTH; i++) avsWrite(2'd0, 32'(i + 1));
        avsWrite(2'd0, 32'd200);
        avsRead(2'd1, rd);
        vecCount++;
        if (rd !== 32'h0000_100C) begin errCount++; $display("FAIL ovf_status got %h exp %h", rd, 32'h100C); end
        avsWrite(2'd1, 32'h1);
        waitDone(ok, rd);
        vecCount++;
        if (!ok || rd !== 32'h0000_100E) begin errCount++; $display("FAIL ovf_done got %h ok=%0b exp %h", rd, ok, 32'h100E); end
        avsRead(2'd2, rd);
        vecCount++;
        if (rd !== expRes(16'd16, 16'd1)) begin errCount++; $display("FAIL ovf_val got %h exp %h", rd, expRes(16'd16, 16'd1)); end
        avsRead(2'd3, rd);
        vecCount++;
        if (rd !== expRes(16'd15, 16'd0)) begin errCount++; $display("FAIL ovf_idx got %h exp %h", rd, expRes(16'd15, 16'd0)); end
    endtask

    task automatic test_empty();
        logic [31:0] rd;
        avsWrite(2'd1, 32'h2);
        avsWrite(2'd1, 32'h1);
        avsRead(2'd1, rd);
        vecCount++;
        if (rd !== 32'h0000_0012) begin errCount++; $display("FAIL empty_status got %h exp %h", rd, 32'h12); end
        avsRead(2'd2, rd);
        vecCount++;
        if (rd !== 32'd0) begin errCount++; $display("FAIL empty_val got %h exp %h", rd, 32'd0); end
        avsRead(2'd3, rd);
        vecCount++;
        if (rd !== 32'd0) begin errCount++; $display("FAIL empty_idx got %h exp %h", rd, 32'd0); end
    endtask

    task automatic test_truncate();
        logic [31:0] rd;
        logic ok;
        avsWrite(2'd1, 32'h2);
        avsWrite(2'd0, 32'h1FF);
        avsWrite(2'd0, 32'h10);
        avsWrite(2'd1, 32'h1);
        waitDone(ok, rd);
        vecCount++;
        if (!ok || rd !== 32'h0000_0202) begin errCount++; $display("FAIL trunc_done got %h ok=%0b exp %h", rd, ok, 32'h202); end
        avsWrite(2'd0, 32'h20);
        avsRead(2'd2, rd);
        vecCount++;
        if (rd !== expRes(16'hFF, 16'h10)) begin errCount++; $display("FAIL trunc_val got %h exp %h", rd, expRes(16'hFF, 16'h10)); end
        avsRead(2'd3, rd);
        vecCount++;
        if (rd !== expRes(16'd0, 16'd1)) begin errCount++; $display("FAIL trunc_idx got %h exp %h", rd, expRes(16'd0, 16'd1)); end
        avsRead(2'd0, rd);
        vecCount++;
        if (rd !== 32'd3) begin errCount++; $display("FAIL done_push_count got %h exp %h", rd, 32'd3); end
    endtask

    task automatic test_busy_push();
        logic [31:0] rd;
        logic ok;
        avsWrite(2'd1, 32'h2);
        avsWrite(2'd0, 32'd1); avsWrite(2'd0, 32'd2); avsWrite(2'd0, 32'd3);
        avsWrite(2'd1, 32'h1);
        avsWrite(2'd0, 32'd50);
        avsWrite(2'd1, 32'h1);
        waitDone(ok, rd);
        vecCount++;
        if (!ok || rd !== 32'h0000_030A) begin errCount++; $display("FAIL busy_push_status got %h ok=%0b exp %h", rd, ok, 32'h30A); end
        avsRead(2'd2, rd);
        vecCount++;
        if (rd !== expRes(16'd3, 16'd1)) begin errCount++; $display("FAIL busy_push_val got %h exp %h", rd, expRes(16'd3, 16'd1)); end
    endtask

    task automatic test_clear_midscan();
        logic [31:0] rd;
        logic ok;
        avsWrite(2'd1, 32'h2);
        for (int i = 0; i < DEPTH; i++) avsWrite(2'd0, 32'(100 + i));
        avsWrite(2'd1, 32'h1);
        repeat (3) @(negedge iClk);
        avsWrite(2'd1, 32'h3);
        avsRead(2'd1, rd);
        vecCount++;
        if (rd !== 32'd0) begin errCount++; $display("FAIL clear_status got %h exp %h", rd, 32'd0); end
        avsRead(2'd2, rd);
        vecCount++;
        if (rd !== 32'd0) begin errCount++; $display("FAIL clear_val got %h exp %h", rd, 32'd0); end
        avsWrite(2'd0, 32'd7);
        avsWrite(2'd0, 32'd4);
        avsWrite(2'd1, 32'h1);
        waitDone(ok, rd);
        vecCount++;
        if (!ok || rd !== 32'h0000_0202) begin errCount++; $display("FAIL clear_rescan_status got %h ok=%0b exp %h", rd, ok, 32'h202); end
        avsRead(2'd2, rd);
        vecCount++;
        if (rd !== expRes(16'd7, 16'd4)) begin errCount++; $display("FAIL clear_rescan_val got %h exp %h", rd, expRes(16'd7, 16'd4)); end
        avsRead(2'd3, rd);
        vecCount++;
        if (rd !== expRes(16'd0, 16'd1)) begin errCount++; $display("FAIL clear_rescan_idx got %h exp %h", rd, expRes(16'd0, 16'd1)); end
    endtask

    task automatic test_reset_midscan();
        logic [31:0] rd;
        for (int i = 0; i < 6; i++) avsWrite(2'd0, 32'(i));
        avsWrite(2'd1, 32'h1);
        @(negedge iClk);
        iReset_n = 1'b0;
        @(negedge iClk);
        iReset_n = 1'b1;
        avsRead(2'd1, rd);
        vecCount++;
        if (rd !== 32'd0) begin errCount++; $display("FAIL reset_midscan_status got %h exp %h", rd, 32'd0); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_overflow();
        test_empty();
        test_truncate();
        test_busy_push();
        test_clear_midscan();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
